sim_run_ctrl: RTL and testbench

Parametrised run-control monitor that replaces the fixed-duration simulation stop of the top-level processor bench. It sits beside the `riscv` core, snoops the fetched PC/instruction and the register-file write port, and detects program termination (ECALL, EBREAK, or a `jal x0,0` self-loop). On termination it reports pass/fail from a shadowed `a0` (x10), and a cycle watchdog bounds every run. It is synthesizable and also usable on FPGA as a test-status latch.

---
 rtl/sim_run_ctrl_if.sv | 32 +++
 rtl/sim_run_ctrl.sv | 153 +++++++++++++++
 tb/tb_sim_run_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/sim_run_ctrl_if.sv
// Snoop bus between a retiring core and the run-control monitor, plus the
// monitor's status outputs. The core side is master, the monitor is slave.
interface sim_run_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             en;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             rf_we;
  logic [4:0]       rf_waddr;
  logic [XLEN-1:0]  rf_wdata;

  logic             done;
  logic             pass;
  logic             fail;
  logic             timeout;
  logic [1:0]       halt_cause;
  logic [XLEN-1:0]  exit_code;
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] instret_cnt;

  modport master (
    output en, pc, instr, rf_we, rf_waddr, rf_wdata,
    input  done, pass, fail, timeout, halt_cause, exit_code, cycle_cnt, instret_cnt
  );

  modport slave (
    input  en, pc, instr, rf_we, rf_waddr, rf_wdata,
    output done, pass, fail, timeout, halt_cause, exit_code, cycle_cnt, instret_cnt
  );
endinterface

// File: rtl/sim_run_ctrl.sv
// Run-control monitor: detects ECALL / EBREAK / jal-self-loop termination,
// reports pass/fail from a shadowed a0, and bounds the run with a watchdog.
module sim_run_ctrl #(
  parameter int              XLEN        = 32,
  parameter int              CNT_W       = 32,
  parameter int              TIMEOUT     = 1000,
  parameter int              LOOP_THRESH = 4,
  parameter int              DRAIN       = 2,
  parameter logic [XLEN-1:0] PASS_CODE   = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  sim_run_ctrl_if.slave bus
);

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_JAL0   = 32'h0000_006F;

  localparam int LOOP_W  = $clog2(LOOP_THRESH + 1);
  localparam int DRAIN_W = (DRAIN < 2) ? 1 : $clog2(DRAIN);

  localparam logic [LOOP_W-1:0]  LOOP_LAST    = LOOP_W'(LOOP_THRESH - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD   = (DRAIN == 0) ? '0 : DRAIN_W'(DRAIN - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   CNT_MAX      = '1;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t             r_state;
  logic [LOOP_W-1:0]  r_loop_cnt;
  logic [XLEN-1:0]    r_prev_pc;
  logic [XLEN-1:0]    r_a0;
  logic [DRAIN_W-1:0] r_drain_cnt;
  logic [CNT_W-1:0]   r_cycle_cnt;
  logic [CNT_W-1:0]   r_instret_cnt;
  logic               r_done;
  logic               r_pass;
  logic               r_fail;
  logic               r_timeout;
  logic [1:0]         r_halt_cause;
  logic [XLEN-1:0]    r_exit_code;

  logic              w_run;
  logic              w_retire;
  logic              w_ecall;
  logic              w_ebreak;
  logic              w_jal;
  logic [LOOP_W-1:0] w_loop_next;
  logic              w_loop_halt;
  logic              w_halt;
  logic              w_wdog;
  logic              w_a0_we;
  logic [XLEN-1:0]   w_a0_next;
  logic              w_enter_done;
  logic [1:0]        w_cause;

  assign w_run    = (r_state == ST_RUN);
  assign w_retire = bus.en && w_run;
  assign w_ecall  = w_retire && (bus.instr == INSTR_ECALL);
  assign w_ebreak = w_retire && (bus.instr == INSTR_EBREAK);
  assign w_jal    = w_retire && (bus.instr == INSTR_JAL0);

  // The first jal of a streak leaves the count at 0, so LOOP_THRESH hits are needed.
  assign w_loop_next = (w_jal && (bus.pc == r_prev_pc)) ? r_loop_cnt + 1'b1 : '0;
  assign w_loop_halt = w_jal && (w_loop_next == LOOP_LAST);
  assign w_halt      = w_ecall || w_ebreak || w_loop_halt;
  assign w_wdog      = w_run && !w_halt && (r_cycle_cnt == TIMEOUT_LAST);

  // Forward a same-cycle a0 write into the value frozen on entry to DONE.
  assign w_a0_we   = (r_state != ST_DONE) && bus.rf_we && (bus.rf_waddr == 5'd10);
  assign w_a0_next = w_a0_we ? bus.rf_wdata : r_a0;

  assign w_enter_done = (w_run && ((w_halt && (DRAIN == 0)) || w_wdog)) ||
                        ((r_state == ST_DRAIN) && (r_drain_cnt == '0));

  // NOTE: default assigned first so every path drives w_cause and no latch is inferred.
  always_comb begin
    w_cause = 2'd0;
    if (w_ecall)          w_cause = 2'd1;
    else if (w_ebreak)    w_cause = 2'd2;
    else if (w_loop_halt) w_cause = 2'd3;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_loop_cnt    <= '0;
      r_prev_pc     <= '0;
      r_a0          <= '0;
      r_drain_cnt   <= '0;
      r_cycle_cnt   <= '0;
      r_instret_cnt <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
      r_halt_cause  <= 2'd0;
      r_exit_code   <= '0;
    end else begin
      if (w_a0_we) r_a0 <= bus.rf_wdata;

      if ((r_state != ST_DONE) && (r_cycle_cnt != CNT_MAX))
        r_cycle_cnt <= r_cycle_cnt + 1'b1;

      if (w_retire) begin
        if (r_instret_cnt != CNT_MAX) r_instret_cnt <= r_instret_cnt + 1'b1;
        r_prev_pc  <= bus.pc;
        r_loop_cnt <= w_loop_next;
      end

      if (w_enter_done) begin
        r_done      <= 1'b1;
        r_timeout   <= w_wdog;
        r_exit_code <= w_a0_next;
        r_pass      <= !w_wdog && (w_a0_next == PASS_CODE);
        r_fail      <= w_wdog || (w_a0_next != PASS_CODE);
      end

      unique case (r_state)
        ST_RUN: begin
          if (w_halt) begin
            r_halt_cause <= w_cause;
            if (DRAIN == 0) begin
              r_state <= ST_DONE;
            end else begin
              r_state     <= ST_DRAIN;
              r_drain_cnt <= DRAIN_LOAD;
            end
          end else if (w_wdog) begin
            r_state <= ST_DONE;
          end
        end
        ST_DRAIN: begin
          if (r_drain_cnt == '0) r_state <= ST_DONE;
          else                   r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.timeout     = r_timeout;
  assign bus.halt_cause  = r_halt_cause;
  assign bus.exit_code   = r_exit_code;
  assign bus.cycle_cnt   = r_cycle_cnt;
  assign bus.instret_cnt = r_instret_cnt;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Directed bench for sim_run_ctrl: dut_a drains 2 cycles with a 20-cycle watchdog,
// dut_b has no drain; both see identical stimulus.
module tb_sim_run_ctrl;

  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] JAL0   = 32'h0000_006F;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  sim_run_ctrl_if #(.XLEN(32), .CNT_W(32)) if_a ();
  sim_run_ctrl_if #(.XLEN(32), .CNT_W(32)) if_b ();

  sim_run_ctrl #(
    .XLEN(32), .CNT_W(32), .TIMEOUT(20), .LOOP_THRESH(4), .DRAIN(2), .PASS_CODE(32'd0)
  ) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  sim_run_ctrl #(
    .XLEN(32), .CNT_W(32), .TIMEOUT(1000), .LOOP_THRESH(4), .DRAIN(0), .PASS_CODE(32'd0)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs to both monitors, then sample 1 ns after the edge.
  task automatic drive(input logic en, input logic [31:0] pc, input logic [31:0] instr,
                       input logic we, input logic [4:0] waddr, input logic [31:0] wdata);
    if_a.en = en; if_a.pc = pc; if_a.instr = instr;
    if_a.rf_we = we; if_a.rf_waddr = waddr; if_a.rf_wdata = wdata;
    if_b.en = en; if_b.pc = pc; if_b.instr = instr;
    if_b.rf_we = we; if_b.rf_waddr = waddr; if_b.rf_wdata = wdata;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired, expected finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b1;

    // Reset state
    do_reset();
    check("rst_done",    64'(if_a.done),        64'd0);
    check("rst_pass",    64'(if_a.pass),        64'd0);
    check("rst_fail",    64'(if_a.fail),        64'd0);
    check("rst_timeout", 64'(if_a.timeout),     64'd0);
    check("rst_cause",   64'(if_a.halt_cause),  64'd0);
    check("rst_exit",    64'(if_a.exit_code),   64'd0);
    check("rst_cycle",   64'(if_a.cycle_cnt),   64'd0);
    check("rst_instret", 64'(if_a.instret_cnt), 64'd0);

    // ECALL pass after 11 retirements
    for (int i = 0; i < 10; i++)
      drive(1'b1, 32'(i * 4), NOP, (i == 0), 5'd10, 32'd0);
    drive(1'b1, 32'd40, ECALL, 1'b0, 5'd0, 32'd0);
    check("ecall_a_done_e0",  64'(if_a.done),        64'd0);
    check("ecall_b_done_e0",  64'(if_b.done),        64'd1);
    check("ecall_b_instret",  64'(if_b.instret_cnt), 64'd11);
    check("ecall_b_cycle",    64'(if_b.cycle_cnt),   64'd11);
    idle();
    check("ecall_a_done_e1",  64'(if_a.done),        64'd0);
    idle();
    check("ecall_a_done_e2",  64'(if_a.done),        64'd1);
    check("ecall_a_pass",     64'(if_a.pass),        64'd1);
    check("ecall_a_fail",     64'(if_a.fail),        64'd0);
    check("ecall_a_cause",    64'(if_a.halt_cause),  64'd1);
    check("ecall_a_exit",     64'(if_a.exit_code),   64'd0);
    check("ecall_a_instret",  64'(if_a.instret_cnt), 64'd11);
    check("ecall_a_cycle",    64'(if_a.cycle_cnt),   64'd13);
    check("ecall_a_timeout",  64'(if_a.timeout),     64'd0);
    drive(1'b1, 32'd44, NOP, 1'b1, 5'd10, 32'd99);
    check("done_hold_exit",    64'(if_a.exit_code),   64'd0);
    check("done_hold_instret", 64'(if_a.instret_cnt), 64'd11);
    check("done_hold_cycle",   64'(if_a.cycle_cnt),   64'd13);

    // EBREAK with an a0 write landing during drain
    do_reset();
    drive(1'b1, 32'd0, NOP, 1'b1, 5'd10, 32'd0);
    drive(1'b1, 32'd4, NOP, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'd8, EBREAK, 1'b0, 5'd0, 32'd0);
    check("ebreak_b_done",  64'(if_b.done),       64'd1);
    check("ebreak_b_pass",  64'(if_b.pass),       64'd1);
    check("ebreak_b_cause", 64'(if_b.halt_cause), 64'd2);
    drive(1'b0, 32'd0, 32'd0, 1'b1, 5'd10, 32'd5);
    check("ebreak_a_done_e1", 64'(if_a.done), 64'd0);
    idle();
    check("ebreak_a_done",  64'(if_a.done),       64'd1);
    check("ebreak_a_fail",  64'(if_a.fail),       64'd1);
    check("ebreak_a_pass",  64'(if_a.pass),       64'd0);
    check("ebreak_a_exit",  64'(if_a.exit_code),  64'd5);
    check("ebreak_a_cause", 64'(if_a.halt_cause), 64'd2);
    check("ebreak_b_exit",  64'(if_b.exit_code),  64'd0);

    // Self-loop: four jal x0,0 at the same PC
    do_reset();
    drive(1'b1, 32'h3C, NOP, 1'b0, 5'd0, 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    check("loop_done_3", 64'(if_b.done), 64'd0);
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    check("loop_done_4",  64'(if_b.done),        64'd1);
    check("loop_cause",   64'(if_b.halt_cause),  64'd3);
    check("loop_instret", 64'(if_b.instret_cnt), 64'd5);

    // Self-loop with a bubble in the middle
    do_reset();
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    drive(1'b0, 32'h44, JAL0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    check("bubble_done_3", 64'(if_b.done), 64'd0);
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    check("bubble_done_4", 64'(if_b.done),       64'd1);
    check("bubble_cause",  64'(if_b.halt_cause), 64'd3);

    // PC changes on the 3rd retirement: streak restarts
    do_reset();
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h40, JAL0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h44, JAL0, 1'b0, 5'd0, 32'd0);
    drive(1'b1, 32'h44, JAL0, 1'b0, 5'd0, 32'd0);
    check("pcchg_done_4", 64'(if_b.done), 64'd0);
    drive(1'b1, 32'h44, JAL0, 1'b0, 5'd0, 32'd0);
    check("pcchg_done_5", 64'(if_b.done), 64'd0);
    check("pcchg_a_done", 64'(if_a.done), 64'd0);

    // Watchdog: 20 cycles without a halt
    do_reset();
    for (int i = 0; i < 19; i++) drive(1'b1, 32'(i * 4), NOP, 1'b0, 5'd0, 32'd0);
    check("wdog_cycle_19", 64'(if_a.cycle_cnt), 64'd19);
    check("wdog_done_19",  64'(if_a.done),      64'd0);
    drive(1'b1, 32'd76, NOP, 1'b0, 5'd0, 32'd0);
    check("wdog_done",    64'(if_a.done),       64'd1);
    check("wdog_timeout", 64'(if_a.timeout),    64'd1);
    check("wdog_fail",    64'(if_a.fail),       64'd1);
    check("wdog_pass",    64'(if_a.pass),       64'd0);
    check("wdog_cycle",   64'(if_a.cycle_cnt),  64'd20);
    check("wdog_cause",   64'(if_a.halt_cause), 64'd0);
    check("wdog_b_done",  64'(if_b.done),       64'd0);

    // Halt and watchdog on the same cycle: halt wins
    do_reset();
    for (int i = 0; i < 19; i++) drive(1'b1, 32'(i * 4), NOP, (i == 0), 5'd10, 32'd0);
    drive(1'b1, 32'd76, ECALL, 1'b0, 5'd0, 32'd0);
    check("tie_done_e0",    64'(if_a.done),    64'd0);
    check("tie_timeout_e0", 64'(if_a.timeout), 64'd0);
    idle();
    idle();
    check("tie_done",    64'(if_a.done),       64'd1);
    check("tie_timeout", 64'(if_a.timeout),    64'd0);
    check("tie_cause",   64'(if_a.halt_cause), 64'd1);
    check("tie_pass",    64'(if_a.pass),       64'd1);
    check("tie_cycle",   64'(if_a.cycle_cnt),  64'd22);

    // Asynchronous reset in the middle of drain
    do_reset();
    drive(1'b1, 32'd0, NOP, 1'b1, 5'd10, 32'd7);
    drive(1'b1, 32'd4, ECALL, 1'b0, 5'd0, 32'd0);
    idle();
    check("mid_cause_pre", 64'(if_a.halt_cause), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_cause",   64'(if_a.halt_cause),  64'd0);
    check("mid_rst_cycle",   64'(if_a.cycle_cnt),   64'd0);
    check("mid_rst_instret", 64'(if_a.instret_cnt), 64'd0);
    check("mid_rst_done",    64'(if_a.done),        64'd0);
    check("mid_rst_b_done",  64'(if_b.done),        64'd0);
    check("mid_rst_b_exit",  64'(if_b.exit_code),   64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 32'd0, ECALL, 1'b0, 5'd0, 32'd0);
    idle();
    idle();
    check("rerun_done",    64'(if_a.done),        64'd1);
    check("rerun_pass",    64'(if_a.pass),        64'd1);
    check("rerun_exit",    64'(if_a.exit_code),   64'd0);
    check("rerun_cause",   64'(if_a.halt_cause),  64'd1);
    check("rerun_instret", 64'(if_a.instret_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
